// File: rtl/fifo_reader_if.sv
// Handshake bundle between the FIFO, the byte-pair reader and the word sink.
// master: the reader itself; slave: the surrounding FIFO and downstream logic.
interface fifo_reader_if;
  logic        fifo_empty;
  logic [3:0]  fifo_count;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_pad;
  logic [7:0]  words_sent;

  modport master (
    input  fifo_empty, fifo_count, fifo_data, flush, out_ready,
    output fifo_rd, out_data, out_valid, out_pad, words_sent
  );

  modport slave (
    output fifo_empty, fifo_count, fifo_data, flush, out_ready,
    input  fifo_rd, out_data, out_valid, out_pad, words_sent
  );
endinterface

// File: rtl/fifo_reader.sv
// Pops bytes from a FIFO in pairs and presents them as 16-bit words
// {second, first}. A lone trailing byte is emitted zero-padded when flush is
// held. fifo_data is valid the cycle after a pop strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for >=2 bytes, or flush with a lone byte
// RD_LO  | pop strobe for the first byte
// CAP_LO | capture first byte; pop second byte if pairing
// CAP_HI | capture second byte
// OUT    | word presented, held until out_ready
module fifo_reader (
  input  logic          clk,
  input  logic          rst,
  fifo_reader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    CAP_LO = 3'd2,
    CAP_HI = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        pair;
  logic        pair_nxt;
  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;
  logic        pad;
  logic [7:0]  words_sent;
  logic        fifo_rd;
  logic        out_valid;
  logic        start_pair;
  logic        start_lone;
  logic        accept;

  // A pair takes priority over a flush so flush never splits a full pair.
  assign start_pair = (bus.fifo_count >= 4'd2);
  assign start_lone = bus.flush && !bus.fifo_empty;
  assign accept     = (state == OUT) && bus.out_ready;

  // State and pair-flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pair  <= 1'b0;
    end else begin
      state <= state_nxt;
      pair  <= pair_nxt;
    end
  end

  // Next-state logic; fifo_rd and out_valid depend only on state and pair.
  always_comb begin
    state_nxt = state;
    pair_nxt  = pair;
    fifo_rd   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start_pair) begin
          state_nxt = RD_LO;
          pair_nxt  = 1'b1;
        end else if (start_lone) begin
          state_nxt = RD_LO;
          pair_nxt  = 1'b0;
        end
      end
      RD_LO: begin
        fifo_rd   = 1'b1;
        state_nxt = CAP_LO;
      end
      CAP_LO: begin
        fifo_rd   = pair;
        state_nxt = pair ? CAP_HI : OUT;
      end
      CAP_HI: begin
        state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte capture; a lone byte gets a zero high byte and the pad marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_byte <= 8'h00;
      hi_byte <= 8'h00;
      pad     <= 1'b0;
    end else begin
      case (state)
        CAP_LO: begin
          lo_byte <= bus.fifo_data;
          if (!pair) begin
            hi_byte <= 8'h00;
            pad     <= 1'b1;
          end
        end
        CAP_HI: begin
          hi_byte <= bus.fifo_data;
          pad     <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Accepted-word counter, wrapping modulo 256.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words_sent <= 8'h00;
    end else if (accept) begin
      words_sent <= words_sent + 8'd1;
    end
  end

  assign bus.fifo_rd    = fifo_rd;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = {hi_byte, lo_byte};
  assign bus.out_pad    = pad;
  assign bus.words_sent = words_sent;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and randomized bench for fifo_reader. A simple array FIFO feeds the
// DUT; accepted words are collected and compared to words built from the
// pushed byte stream (pairs in push order, lone bytes zero-padded).
module tb_fifo_reader;

  logic clk;
  logic rst;

  fifo_reader_if bus ();

  fifo_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte FIFO model: pushes from the stimulus, pops on fifo_rd at the edge.
  logic [7:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         occ;
  logic [7:0] fifo_data_q = 8'h00;
  int         pops = 0;
  int         underflow = 0;

  assign occ            = wr_ptr - rd_ptr;
  assign bus.fifo_empty = (occ == 0);
  assign bus.fifo_count = (occ > 15) ? 4'd15 : 4'(occ);
  assign bus.fifo_data  = fifo_data_q;

  // Pop side of the FIFO model; flags any pop attempted on an empty FIFO.
  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      pops <= pops + 1;
      if (occ == 0) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data_q <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1;
      end
    end
  end

  // Monitor: records accepted words and flags any change while stalled.
  logic [16:0] obs [$];
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  int          hold_viol = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (bus.out_valid && bus.out_ready) obs.push_back({bus.out_pad, bus.out_data});
      if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) hold_viol <= hold_viol + 1;
      prev_hold <= bus.out_valid && !bus.out_ready;
      prev_data <= bus.out_data;
    end else begin
      prev_hold <= 1'b0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    obs.delete();
    rst = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(obs.size() >= n), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int seen;
    logic [7:0] bytes [$];
    int cyc;

    rst = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pad", 32'(bus.out_pad), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h0000);
    check("rst_words_sent", 32'(bus.words_sent), 32'd0);
    rst = 1'b1;

    // Four bytes stream out as two words.
    @(negedge clk);
    bus.out_ready = 1'b1;
    p0 = pops;
    push(8'd10); push(8'd20); push(8'd30); push(8'd40);
    wait_obs(2, 60, "two_words_timeout");
    check("word0", 32'(obs[0]), 32'h0140A);
    check("word1", 32'(obs[1]), 32'h0281E);
    @(negedge clk);
    check("two_words_sent", 32'(bus.words_sent), 32'd2);
    check("two_words_pops", 32'(pops - p0), 32'd4);

    // Lone byte waits without flush, then leaves padded.
    do_reset();
    bus.out_ready = 1'b1;
    p0 = pops;
    push(8'd55);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.out_valid || bus.fifo_rd) seen++;
    end
    check("lone_no_activity", 32'(seen), 32'd0);
    check("lone_no_pop", 32'(pops - p0), 32'd0);
    bus.flush = 1'b1;
    wait_obs(1, 20, "flush_timeout");
    bus.flush = 1'b0;
    check("flush_word", 32'(obs[0]), 32'h10037);
    @(negedge clk);
    check("flush_words_sent", 32'(bus.words_sent), 32'd1);
    check("flush_pops", 32'(pops - p0), 32'd1);

    // Flush on an empty FIFO and out_ready alone do nothing.
    do_reset();
    p0 = pops;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid || bus.fifo_rd) seen++;
    end
    bus.flush = 1'b0;
    check("empty_flush_activity", 32'(seen), 32'd0);
    check("empty_flush_pops", 32'(pops - p0), 32'd0);
    check("empty_flush_words", 32'(bus.words_sent), 32'd0);

    // Backpressure: latency to out_valid, then the word holds.
    do_reset();
    bus.out_ready = 1'b0;
    @(negedge clk);
    push(8'd10); push(8'd20);
    repeat (3) @(negedge clk);
    check("latency_not_yet", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(bus.out_valid), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'h140A);
      check("hold_words", 32'(bus.words_sent), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_words", 32'(bus.words_sent), 32'd1);
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("hold_monitor", 32'(hold_viol), 32'd0);

    // Reset in CAP_LO: first byte is lost, second leaves padded on flush.
    do_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    p0 = pops;
    push(8'h11); push(8'h22);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("cap_lo_rd", 32'(bus.fifo_rd), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rd", 32'(bus.fifo_rd), 32'd0);
    check("async_valid", 32'(bus.out_valid), 32'd0);
    check("async_words", 32'(bus.words_sent), 32'd0);
    check("async_data", 32'(bus.out_data), 32'h0000);
    @(negedge clk);
    rst = 1'b1;
    obs.delete();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid || bus.fifo_rd) seen++;
    end
    check("post_reset_idle", 32'(seen), 32'd0);
    check("post_reset_pops", 32'(pops - p0), 32'd1);
    bus.flush = 1'b1;
    wait_obs(1, 20, "post_reset_flush_timeout");
    bus.flush = 1'b0;
    check("post_reset_word", 32'(obs[0]), 32'h10022);

    // Randomized stream of 512 pairs with random backpressure.
    do_reset();
    p0 = pops;
    bytes.delete();
    cyc = 0;
    while (obs.size() < 512 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bytes.size() < 1024 && occ < 12 && $urandom_range(0, 1) == 1) begin
        logic [7:0] b;
        b = 8'($urandom);
        bytes.push_back(b);
        push(b);
      end
    end
    check("stream_count", 32'(obs.size()), 32'd512);
    seen = 0;
    for (int i = 0; i < 512 && i < obs.size(); i++) begin
      if (obs[i] !== {1'b0, bytes[2*i+1], bytes[2*i]}) seen++;
    end
    check("stream_word_mismatches", 32'(seen), 32'd0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("stream_wrap", 32'(bus.words_sent), 32'd0);
    check("stream_pops", 32'(pops - p0), 32'd1024);
    check("no_underflow", 32'(underflow), 32'd0);
    check("stream_hold", 32'(hold_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: none; FIFO data width fixed at 8 bits, count width fixed at 4 bits.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 fifo_empty  input  1  FIFO empty flag.
REQ-005 fifo_count  input  4  number of bytes currently held in FIFO.
REQ-006 fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd is high.
REQ-007 fifo_rd  output  1  FIFO pop strobe, one byte per high cycle.
REQ-008 flush  input  1  level; allows a lone trailing byte to be emitted as a padded word.
REQ-009 out_data  output  16  packed word {second byte, first byte}.
REQ-010 out_valid  output  1  out_data valid, held until accepted.
REQ-011 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-012 out_pad  output  1  high with out_valid when out_data[15:8] is padding (0x00).
REQ-013 words_sent  output  8  count of accepted words, wraps 255 -> 0.

Function
REQ-014 FSM states SHALL be IDLE, RD_LO, CAP_LO, CAP_HI, OUT; fifo_rd and out_valid decoded from state and pair flag only.
REQ-015 IDLE: fifo_rd=0, out_valid=0; if fifo_count>=2 -> RD_LO with pair=1; else if flush && !fifo_empty -> RD_LO with pair=0; else stay.
REQ-016 RD_LO: fifo_rd=1 for exactly one cycle; next CAP_LO.
REQ-017 CAP_LO: lo byte <= fifo_data; fifo_rd=pair; next CAP_HI if pair, else OUT with hi byte <= 0x00, out_pad <= 1.
REQ-018 CAP_HI: fifo_rd=0; hi byte <= fifo_data; out_pad <= 0; next OUT.
REQ-019 OUT: out_valid=1, out_data={hi,lo} stable; on out_ready=1 -> IDLE and words_sent increments by 1 (mod 256); on out_ready=0 stay, all outputs unchanged.
REQ-020 Latency: out_valid rises 4 clocks after the IDLE edge that sees fifo_count>=2 (3 clocks after RD_LO entry) for a pair; 3 clocks for a padded word.
REQ-021 Byte order: first byte popped lands in out_data[7:0], second in out_data[15:8].
REQ-022 fifo_rd SHALL never be high while fifo_empty=1 at the decision point; no more than 2 pops per word.
REQ-023 Minimum word period 5 clocks (OUT accepted in same cycle it is entered, then IDLE).
REQ-024 flush ignored outside IDLE; flush with fifo_count>=2 still yields a full pair (pair=1).
REQ-025 flush with fifo_empty=1 SHALL cause no pop and no output.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst=0 SHALL immediately (asynchronously) force state=IDLE, fifo_rd=0, out_valid=0, out_pad=0, out_data=16'h0000, words_sent=0, pair=0.
REQ-028 Reset mid-word SHALL discard any captured partial byte; bytes already popped are lost, no recovery.
REQ-029 After rst returns to 1, first action no earlier than the next rising edge in IDLE.

Verification
REQ-030 Write 10,20,30,40 into FIFO, out_ready=1 -> two words 16'h140A then 16'h281E, out_pad=0, words_sent=2, 4 fifo_rd pulses total.
REQ-031 Write single byte 55 with flush=0 -> no fifo_rd, out_valid stays 0 for 50 clocks; then flush=1 -> out_data=16'h0037, out_pad=1, words_sent=1.
REQ-032 Write 10,20 with out_ready=0 for 10 clocks -> out_valid held high, out_data=16'h140A stable, words_sent=0; raise out_ready -> words_sent=1 next edge.
REQ-033 Assert rst=0 during CAP_LO -> fifo_rd and out_valid drop same cycle, words_sent=0, FSM in IDLE after release.
REQ-034 Stream 512 pairs with out_ready=1 -> words_sent wraps to 0, no pop while fifo_empty=1 ever observed.
